// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the data-memory responder.
package dmem_pkg;

  localparam logic [15:0] MMIO_BASE = 16'h8000;
  localparam logic [3:0]  OUT_OFS   = 4'h0;
  localparam logic [3:0]  IN_OFS    = 4'h4;
  localparam logic [3:0]  TIMER_OFS = 4'h8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_ram_sp.sv
// Single-port synchronous RAM, DEPTH x 32, write-first, one-cycle read latency.
module dmem_ram_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM plus OUT/IN MMIO registers with ready/err handshake.
// Optional free-running TIMER at 0x8008 when DMEM_TIMER_EN is defined.
module data_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int IO_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            ready,
  output logic            err,
  output logic [IO_W-1:0] io_out,
  input  logic [IO_W-1:0] io_in
);

  import dmem_pkg::*;

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  dmem_state_t     state;
  logic [IO_W-1:0] io_in_q;
  logic [31:0]     ram_q;
  logic [31:0]     ram_idx;
  logic [31:0]     mmio_rd;
  logic            base_ok, mmio_blk;
  logic            is_ram, is_out, is_in, is_tmr, fault;
  logic            accept, ram_en;

`ifdef DMEM_TIMER_EN
  logic [31:0]     timer;
`endif

  always_comb begin
    ram_idx  = {19'b0, addr[14:2]};
    base_ok  = (addr[31:16] == 16'h0000) && (addr[1:0] == 2'b00);
    mmio_blk = (addr[15:4] == MMIO_BASE[15:4]);
    is_ram   = base_ok && !addr[15] && (ram_idx < DEPTH_U);
    is_out   = base_ok && mmio_blk && (addr[3:0] == OUT_OFS);
    is_in    = base_ok && mmio_blk && (addr[3:0] == IN_OFS) && !we;
`ifdef DMEM_TIMER_EN
    is_tmr   = base_ok && mmio_blk && (addr[3:0] == TIMER_OFS);
`else
    is_tmr   = 1'b0;
`endif
    fault    = !(is_ram || is_out || is_in || is_tmr);
  end

  always_comb begin
    mmio_rd = '0;
    if (is_out)
      mmio_rd[IO_W-1:0] = io_out;
    else if (is_in)
      mmio_rd[IO_W-1:0] = io_in_q;
`ifdef DMEM_TIMER_EN
    else if (is_tmr)
      mmio_rd = timer;
`endif
  end

  // Decode runs on the live request at accept and everything it needs is
  // committed on that edge, so no request fields are held afterwards.
  assign accept = (state == IDLE) && req && !rst;
  assign ram_en = accept && is_ram;

  dmem_ram_sp #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (we),
    .addr (addr[AW+1:2]),
    .wdata(wdata),
    .rdata(ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      io_out  <= '0;
      io_in_q <= '0;
`ifdef DMEM_TIMER_EN
      timer   <= '0;
`endif
    end else begin
      io_in_q <= io_in;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
`ifdef DMEM_TIMER_EN
      timer   <= timer + 32'd1;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            if (fault) begin
              ready <= 1'b1;
              err   <= 1'b1;
              state <= RESP;
            end else if (we) begin
              if (is_out)
                io_out <= wdata[IO_W-1:0];
`ifdef DMEM_TIMER_EN
              if (is_tmr)
                timer <= wdata;
`endif
              ready <= 1'b1;
              state <= RESP;
            end else if (is_ram) begin
              state <= WAIT;
            end else begin
              rdata <= mmio_rd;
              ready <= 1'b1;
              state <= RESP;
            end
          end
        end
        WAIT: begin
          rdata <= ram_q;
          ready <= 1'b1;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a behavioural memory/IO/timer model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int IO_W  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req = 1'b0;
  logic            we = 1'b0;
  logic [31:0]     addr = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic            ready;
  logic            err;
  logic [IO_W-1:0] io_out;
  logic [IO_W-1:0] io_in = '0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [31:0]     mem_m [int];
  logic [IO_W-1:0] io_m = '0;

  data_mem_responder #(
    .DEPTH(DEPTH),
    .IO_W (IO_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .err   (err),
    .io_out(io_out),
    .io_in (io_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One transaction; lat = edges from accept to the ready cycle (0 = none within budget).
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat, output int acc);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    acc = cyc; lat = 0; rd = '0; e = 1'b0;
    we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
    for (int i = 1; i <= 8; i++) begin
      if (ready) begin
        lat = i; rd = rdata; e = err;
        break;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else passed++;
    total++; if (io_out !== '0) $display("FAIL reset_io_out got=%h exp=0", io_out); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_ram_rw();
    logic [31:0] rd, d;
    logic e;
    int lat, acc, idx;
    access(1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, acc);
    mem_m[4] = 32'hDEADBEEF;
    total++; if (lat !== 1 || e !== 1'b0) $display("FAIL ram_wr_first lat=%0d err=%b exp lat=1 err=0", lat, e); else passed++;
    access(1'b0, 32'h10, 32'h0, rd, e, lat, acc);
    total++; if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF)
      $display("FAIL ram_rd_first lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=deadbeef", lat, e, rd); else passed++;
    // Boundary: last valid word.
    access(1'b1, (DEPTH - 1) * 4, 32'h0BADF00D, rd, e, lat, acc);
    mem_m[DEPTH - 1] = 32'h0BADF00D;
    total++; if (lat !== 1 || e !== 1'b0) $display("FAIL ram_wr_last lat=%0d err=%b exp lat=1 err=0", lat, e); else passed++;
    access(1'b0, (DEPTH - 1) * 4, 32'h0, rd, e, lat, acc);
    total++; if (lat !== 2 || e !== 1'b0 || rd !== 32'h0BADF00D)
      $display("FAIL ram_rd_last lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=0badf00d", lat, e, rd); else passed++;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 31);
      if (!mem_m.exists(idx) || $urandom_range(0, 1) == 1) begin
        d = $urandom;
        access(1'b1, 32'(idx * 4), d, rd, e, lat, acc);
        mem_m[idx] = d;
        total++; if (lat !== 1 || e !== 1'b0 || rd !== 32'h0)
          $display("FAIL ram_rand_wr idx=%0d lat=%0d err=%b rdata=%h exp lat=1 err=0 rdata=0", idx, lat, e, rd); else passed++;
      end else begin
        access(1'b0, 32'(idx * 4), $urandom, rd, e, lat, acc);
        total++; if (lat !== 2 || e !== 1'b0 || rd !== mem_m[idx])
          $display("FAIL ram_rand_rd idx=%0d lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=%h", idx, lat, e, rd, mem_m[idx]); else passed++;
      end
    end
  endtask

  task automatic test_mmio();
    logic [31:0] rd, d;
    logic e;
    int lat, acc;
    logic [IO_W-1:0] old_in;
    access(1'b1, 32'h8000, 32'h0000A5A5, rd, e, lat, acc);
    io_m = 16'hA5A5;
    total++; if (lat !== 1 || e !== 1'b0 || io_out !== io_m)
      $display("FAIL out_wr lat=%0d err=%b io_out=%h exp lat=1 err=0 io_out=%h", lat, e, io_out, io_m); else passed++;
    access(1'b0, 32'h8000, 32'h0, rd, e, lat, acc);
    total++; if (lat !== 1 || e !== 1'b0 || rd !== 32'h0000A5A5)
      $display("FAIL out_rd lat=%0d err=%b rdata=%h exp lat=1 err=0 rdata=0000a5a5", lat, e, rd); else passed++;
    access(1'b1, 32'h8000, 32'hFFFF1234, rd, e, lat, acc);
    io_m = 16'h1234;
    access(1'b0, 32'h8000, 32'h0, rd, e, lat, acc);
    total++; if (io_out !== io_m || rd !== 32'h00001234)
      $display("FAIL out_trunc io_out=%h rdata=%h exp io_out=1234 rdata=00001234", io_out, rd); else passed++;
    @(negedge clk); io_in = 16'h1234;
    @(posedge clk);
    access(1'b0, 32'h8004, 32'h0, rd, e, lat, acc);
    total++; if (lat !== 1 || e !== 1'b0 || rd !== 32'h00001234)
      $display("FAIL in_rd lat=%0d err=%b rdata=%h exp lat=1 err=0 rdata=00001234", lat, e, rd); else passed++;
    for (int n = 0; n < 6; n++) begin
      d = $urandom;
      @(negedge clk); io_in = d[IO_W-1:0];
      @(posedge clk);
      access(1'b0, 32'h8004, 32'h0, rd, e, lat, acc);
      total++; if (rd !== {16'h0, d[IO_W-1:0]} || e !== 1'b0)
        $display("FAIL in_rand rdata=%h err=%b exp rdata=%h err=0", rd, e, {16'h0, d[IO_W-1:0]}); else passed++;
    end
    // io_in changing in the same cycle as the request is not yet visible.
    old_in = io_in;
    @(negedge clk);
    io_in = ~old_in;
    req = 1'b1; we = 1'b0; addr = 32'h8004;
    @(posedge clk); #1;
    req = 1'b0;
    total++; if (ready !== 1'b1 || rdata !== {16'h0, old_in})
      $display("FAIL in_sync_delay ready=%b rdata=%h exp ready=1 rdata=%h", ready, rdata, {16'h0, old_in}); else passed++;
    @(posedge clk);
  endtask

  task automatic test_faults();
    logic [31:0] rd;
    logic [31:0] fa [8];
    logic        fw [8];
    logic e;
    int lat, acc;
    fa = '{32'h0000_0012, 32'h0001_0000, 32'h0000_8004, 32'h0000_8010,
           32'h0000_800C, 32'h0000_1000, 32'h8000_0010, 32'h0000_8001};
    fw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      access(fw[i], fa[i], $urandom, rd, e, lat, acc);
      total++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0)
        $display("FAIL fault_%0d addr=%h lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=0", i, fa[i], lat, e, rd); else passed++;
    end
    for (int i = 0; i < 6; i++) begin
      access(1'b1, 32'h10 + 32'($urandom_range(1, 3)), $urandom, rd, e, lat, acc);
      total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL fault_misaligned_wr err=%b rdata=%h exp err=1 rdata=0", e, rd); else passed++;
    end
    total++; if (io_out !== io_m) $display("FAIL fault_io_kept io_out=%h exp %h", io_out, io_m); else passed++;
    access(1'b0, 32'h10, 32'h0, rd, e, lat, acc);
    total++; if (rd !== mem_m[4] || e !== 1'b0) $display("FAIL fault_ram_kept rdata=%h err=%b exp rdata=%h err=0", rd, e, mem_m[4]); else passed++;
  endtask

  task automatic test_timer();
    logic [31:0] rd, wv, exp_v;
    logic e;
    int lat, wacc, racc, gap;
`ifdef DMEM_TIMER_EN
    access(1'b1, 32'h8008, 32'hFFFFFFFE, rd, e, lat, wacc);
    total++; if (lat !== 1 || e !== 1'b0) $display("FAIL timer_wr lat=%0d err=%b exp lat=1 err=0", lat, e); else passed++;
    access(1'b0, 32'h8008, 32'h0, rd, e, lat, racc);
    exp_v = 32'hFFFFFFFE + 32'(racc - wacc - 1);
    total++; if (lat !== 1 || e !== 1'b0 || rd !== exp_v)
      $display("FAIL timer_rd_near_wrap lat=%0d err=%b rdata=%h exp lat=1 err=0 rdata=%h", lat, e, rd, exp_v); else passed++;
    for (int n = 0; n < 5; n++) begin
      wv  = (n == 0) ? 32'hFFFFFFFF : $urandom;
      gap = $urandom_range(0, 6);
      access(1'b1, 32'h8008, wv, rd, e, lat, wacc);
      repeat (gap) @(posedge clk);
      access(1'b0, 32'h8008, 32'h0, rd, e, lat, racc);
      exp_v = wv + 32'(racc - wacc - 1);
      total++; if (rd !== exp_v || e !== 1'b0)
        $display("FAIL timer_rand w=%h gap=%0d rdata=%h err=%b exp rdata=%h err=0", wv, gap, rd, e, exp_v); else passed++;
    end
`else
    wv = $urandom;
    access(1'b1, 32'h8008, wv, rd, e, lat, wacc);
    total++; if (lat !== 1 || e !== 1'b1) $display("FAIL timer_off_wr lat=%0d err=%b exp lat=1 err=1", lat, e); else passed++;
    access(1'b0, 32'h8008, 32'h0, rd, e, lat, racc);
    exp_v = 32'h0;
    total++; if (e !== 1'b1 || rd !== exp_v) $display("FAIL timer_off_rd err=%b rdata=%h exp err=1 rdata=0", e, rd); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic e;
    int lat, acc, prev_acc, prev_gap;
    logic [1:0] kind;
    access(1'b1, 32'h20, 32'h11111111, rd, e, lat, prev_acc);
    mem_m[8] = 32'h11111111;
    prev_gap = 2;
    for (int n = 0; n < 12; n++) begin
      kind = 2'($urandom_range(0, 2));
      case (kind)
        2'd0: begin
          access(1'b1, 32'h20, 32'(n) * 32'h01010101, rd, e, lat, acc);
          mem_m[8] = 32'(n) * 32'h01010101;
        end
        2'd1: access(1'b0, 32'h20, 32'h0, rd, e, lat, acc);
        default: access(1'b0, 32'h8000, 32'h0, rd, e, lat, acc);
      endcase
      total++; if (acc - prev_acc !== prev_gap)
        $display("FAIL b2b_spacing n=%0d got=%0d exp=%0d", n, acc - prev_acc, prev_gap); else passed++;
      total++; if (lat !== ((kind == 2'd1) ? 2 : 1) || e !== 1'b0)
        $display("FAIL b2b_lat n=%0d lat=%0d err=%b exp lat=%0d err=0", n, lat, e, (kind == 2'd1) ? 2 : 1); else passed++;
      if (kind == 2'd1) begin
        total++; if (rd !== mem_m[8]) $display("FAIL b2b_rdata n=%0d got=%h exp=%h", n, rd, mem_m[8]); else passed++;
      end
      prev_gap = (kind == 2'd1) ? 3 : 2;
      prev_acc = acc;
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic e;
    int lat, acc, seen;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    io_m = '0;
    total++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || io_out !== '0)
      $display("FAIL abort_outputs ready=%b err=%b rdata=%h io_out=%h exp all 0", ready, err, rdata, io_out); else passed++;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    total++; if (seen !== 0) $display("FAIL abort_no_ready pulses=%0d exp=0", seen); else passed++;
    access(1'b0, 32'h10, 32'h0, rd, e, lat, acc);
    total++; if (lat !== 2 || rd !== mem_m[4])
      $display("FAIL abort_reread lat=%0d rdata=%h exp lat=2 rdata=%h", lat, rd, mem_m[4]); else passed++;
    // A request presented only while reset is high must be ignored.
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h8000; wdata = 32'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    total++; if (seen !== 0 || io_out !== '0)
      $display("FAIL req_during_rst pulses=%0d io_out=%h exp pulses=0 io_out=0", seen, io_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_mmio();
    test_faults();
    test_timer();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the processor's data port. It accepts word read/write requests (address from the ALU result, store data from the register file) and serves them from an internal word-addressed RAM or a small memory-mapped I/O window. It answers each request with a `ready`/`err` handshake, so the datapath can stall on multi-cycle accesses. It sits between the datapath/controller and the board I/O.

## Interface
Parameters:
- `DEPTH`, 1024: RAM depth in 32-bit words (power of two, ≤ 8192).
- `IO_W`, 16: width of the `io_out`/`io_in` board ports.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  1: request valid; the initiator holds it high until `ready`.
- `we`  in  1: 1 = write, 0 = read; sampled at accept.
- `addr`  in  32: byte address; sampled at accept.
- `wdata`  in  32: store data; sampled at accept.
- `rdata`  out  32: read data; valid only while `ready`=1, otherwise 0.
- `ready`  out  1: one-cycle completion pulse.
- `err`  out  1: asserted with `ready` when the access faulted.
- `io_out`  out  IO_W: LED/output register.
- `io_in`  in  IO_W: switch inputs, registered once inside the block.

## Operation
- Address map (uses `addr[15:0]`; `addr[31:16]` must be 0):
  - 0x0000–0x7FFC: RAM, index `addr[14:2]`, which must be < DEPTH.
  - 0x8000: OUT register, read/write; only the low IO_W bits are stored, and reads zero-extend.
  - 0x8004: IN register, read-only; a write faults.
  - 0x8008: TIMER (see Configuration).
- Fault conditions: `addr[1:0]`≠0, `addr[31:16]`≠0, RAM index ≥ DEPTH, any unmapped MMIO word, or a write to IN.
  - A faulting access returns `ready`=1, `err`=1, `rdata`=0.
  - A faulting access changes no state.
- FSM:
  - IDLE: if `req`=1, latch `addr`/`we`/`wdata` and decode.
    - Fault, write, or MMIO read: go to RESP.
    - RAM read: go to WAIT.
  - WAIT: the synchronous RAM output becomes available; go to RESP.
  - RESP: drive `ready`=1 with `rdata`/`err`; go to IDLE.
- Writes take effect at the accept edge (IDLE→RESP).
- Reads are captured into an output register in the state before RESP.
- Changes on `req`/`addr`/`wdata` after accept are ignored.
- While in RESP, `req` is not sampled. A held `req` in the cycle after `ready` is treated as a new request, so the initiator must drop `req` on the `ready` cycle.

## Timing
- Reset values: `ready`=0, `err`=0, `rdata`=0, `io_out`=0, TIMER=0, FSM=IDLE, IN sync register=0.
  - RAM contents are not reset.
- `rst` during WAIT or RESP aborts the transaction: no `ready` pulse.
  - A write already committed at accept stays committed.
- `req` is ignored in any cycle where `rst`=1.
- Latency from the `req`-sampled edge to the `ready` cycle:
  - Write, fault, or MMIO read: 1 cycle.
  - RAM read: 2 cycles.
- Back-to-back throughput: one access per 2 cycles (write/MMIO), one per 3 cycles (RAM read).
- IN reads return `io_in` as sampled on the previous edge.

## Configuration
- `DMEM_TIMER_EN` defined:
  - 0x8008 is a 32-bit free-running up-counter that increments every cycle and wraps 0xFFFFFFFF→0.
  - A write loads `wdata`. Write beats increment in that cycle, and counting resumes from the written value on the next cycle.
  - A read returns the counter value at the accept edge.
- `DMEM_TIMER_EN` undefined: no counter logic; 0x8008 is unmapped, so reads and writes fault.

## Structure
- Package `dmem_pkg`:
  - Constants: `MMIO_BASE`=16'h8000, `OUT_OFS`=4'h0, `IN_OFS`=4'h4, `TIMER_OFS`=4'h8.
  - FSM state enum `dmem_state_t` {IDLE, WAIT, RESP}.
- Sub-module `dmem_ram_sp`: single-port synchronous RAM, DEPTH×32, write-first, 1-cycle read latency. It maps to block RAM.
- Decode, MMIO registers, timer, and FSM live in `data_mem_responder`.

## Test plan
- Write 0xDEADBEEF to 0x0010, then read 0x0010 → write `ready` 1 cycle after accept with `err`=0; read `ready` 2 cycles after accept with `rdata`=0xDEADBEEF.
- Write 0x0000A5A5 to 0x8000 → `io_out`=0xA5A5. With `io_in`=0x1234, read 0x8004 → `rdata`=0x00001234 after 1 cycle.
- Read 0x0012, read 0x00010000, and write 0x8004 → each gives `ready`=1, `err`=1, `rdata`=0; RAM and `io_out` are unchanged.
- Timer (macro on): write 0xFFFFFFFE to 0x8008, then read 2 cycles later → 0xFFFFFFFF or wrapped value per exact cycle count; the value must be consistent with increment-per-cycle. With the macro off, 0x8008 gives `err`=1.
- Assert `rst` during WAIT of a RAM read → no `ready` pulse, all outputs at reset values. Re-reading the address after reset returns the pre-reset RAM data.
